// File: rtl/systolic_pkg.sv
// Purpose: shared types and sizing helpers for the systolic array sequencer.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: ctrl_state_t state enum, CYCLE_WIDTH, default-size FIRST_OUT/DRAIN_LEN,
//           and constant functions that derive the same values for any array size.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        FEED     = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } ctrl_state_t;

    localparam int CYCLE_WIDTH    = 9;
    localparam int ARRAY_SIZE_DEF = 8;
    localparam int FIRST_OUT      = ARRAY_SIZE_DEF + 1;
    localparam int DRAIN_LEN      = 2 * ARRAY_SIZE_DEF;

    // First cycle_num at which the array presents a finished result.
    function automatic int first_out_of(input int n);
        return n + 1;
    endfunction

    // Number of zero-fed cycles needed to flush the array pipeline.
    function automatic int drain_len_of(input int n);
        return 2 * n;
    endfunction

    // Largest tile count whose job never pushes cycle_num past its maximum.
    function automatic int max_tiles_of(input int n);
        return ((1 << CYCLE_WIDTH) - 1 - 2 * n) / n;
    endfunction

endpackage

// File: rtl/systolic_addr_gen.sv
// Purpose: loadable address counter, +1 per enabled cycle, wraps silently at 2^WIDTH.
// Latency: load/step visible on addr the cycle after the edge that samples them.
// Backpressure: none; en is the only hold mechanism.
// Ports: clk, srstn (sync, active-low), load/load_val (takes priority), en (increment),
//        addr (registered counter value).
module systolic_addr_gen #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] addr
);

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (en) begin
            addr_d = addr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Purpose: sequencer for the ARRAY_SIZE x ARRAY_SIZE systolic MAC array: SRAM read
//          addressing, array enables, result-buffer write strobes for a job of tiles.
// Latency: start -> first alu_start 2 cycles; start -> done 2 + tiles*ARRAY_SIZE + 2*ARRAY_SIZE.
// Backpressure: none; start is only accepted in IDLE and ignored while busy.
// Ports: clk, srstn (sync, active-low); start/tile_num/w_base/d_base/o_base job request;
//        sram_ren/sram_raddr_w/sram_raddr_d input-bank reads; feed_zero/alu_start/cycle_num/
//        matrix_index array controls; out_valid/out_waddr result writes; busy, done status.
// Option: SYSTOLIC_CTRL_PERF_EN adds perf_cycles, a count of alu_start cycles kept across jobs.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ADDR_WIDTH = 10,
    parameter int TILE_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   srstn,
    input  logic                   start,
    input  logic [TILE_WIDTH-1:0]  tile_num,
    input  logic [ADDR_WIDTH-1:0]  w_base,
    input  logic [ADDR_WIDTH-1:0]  d_base,
    input  logic [ADDR_WIDTH-1:0]  o_base,
    output logic                   sram_ren,
    output logic [ADDR_WIDTH-1:0]  sram_raddr_w,
    output logic [ADDR_WIDTH-1:0]  sram_raddr_d,
    output logic                   feed_zero,
    output logic                   alu_start,
    output logic [CYCLE_WIDTH-1:0] cycle_num,
    output logic [5:0]             matrix_index,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  out_waddr,
    output logic                   busy,
    output logic                   done
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int OUT_START = first_out_of(ARRAY_SIZE);
    localparam int DRAIN_CYC = drain_len_of(ARRAY_SIZE);
    localparam int MAX_TILES = max_tiles_of(ARRAY_SIZE);
    localparam logic [CYCLE_WIDTH-1:0] CYC_MAX = '1;

    ctrl_state_t            state_q, state_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [CYCLE_WIDTH-1:0] feed_len_q, feed_len_d;
    logic                   out_valid_q, out_valid_d;
    logic [5:0]             matrix_index_q, matrix_index_d;
    logic                   start_acc;
    logic                   run;
    logic                   feed_last;
    logic                   drain_last;
    logic [31:0]            tiles_eff;
    logic [31:0]            rel_cyc;

    assign start_acc  = (state_q == IDLE) && start;
    assign run        = (state_q == FEED) || (state_q == DRAIN);
    // cycle_num runs 0..feed_len-1 in FEED, then continues through DRAIN, so it
    // doubles as the phase counter for both states.
    assign feed_last  = (state_q == FEED)  && (cycle_q == feed_len_q - CYCLE_WIDTH'(1));
    assign drain_last = (state_q == DRAIN) &&
                        (cycle_q == feed_len_q + CYCLE_WIDTH'(DRAIN_CYC - 1));

    // Job length is fixed at acceptance: 0 tiles means 1, and oversized jobs are
    // clamped so cycle_num can never reach saturation.
    always_comb begin
        tiles_eff = 32'(tile_num);
        if (tiles_eff == 32'd0) begin
            tiles_eff = 32'd1;
        end else if (tiles_eff > 32'(MAX_TILES)) begin
            tiles_eff = 32'(MAX_TILES);
        end
        feed_len_d = feed_len_q;
        if (start_acc) begin
            feed_len_d = CYCLE_WIDTH'(tiles_eff * 32'(ARRAY_SIZE));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start)      state_d = PREFETCH;
            PREFETCH:                 state_d = FEED;
            FEED:     if (feed_last)  state_d = DRAIN;
            DRAIN:    if (drain_last) state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        sram_ren  = 1'b0;
        feed_zero = 1'b0;
        alu_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE:     busy = 1'b0;
            PREFETCH: sram_ren = 1'b1;
            FEED: begin
                alu_start = 1'b1;
                // The final FEED cycle's data was already fetched one cycle earlier.
                sram_ren  = !feed_last;
            end
            DRAIN: begin
                alu_start = 1'b1;
                feed_zero = 1'b1;
            end
            DONE:     done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // cycle_num holds its final value through DONE and is cleared on the way to IDLE.
    // out_valid/matrix_index are computed from the next-cycle values so the registered
    // versions line up with cycle_num.
    always_comb begin
        cycle_d = cycle_q;
        if ((state_q == IDLE) || (state_q == DONE)) begin
            cycle_d = '0;
        end else if (run && !drain_last && (cycle_q != CYC_MAX)) begin
            cycle_d = cycle_q + CYCLE_WIDTH'(1);
        end
        rel_cyc        = 32'(cycle_d) - 32'(OUT_START);
        out_valid_d    = ((state_d == FEED) || (state_d == DRAIN)) &&
                         (32'(cycle_d) >= 32'(OUT_START));
        matrix_index_d = out_valid_d ? 6'(rel_cyc % 32'(DRAIN_CYC)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            cycle_q        <= '0;
            feed_len_q     <= '0;
            out_valid_q    <= 1'b0;
            matrix_index_q <= '0;
        end else begin
            cycle_q        <= cycle_d;
            feed_len_q     <= feed_len_d;
            out_valid_q    <= out_valid_d;
            matrix_index_q <= matrix_index_d;
        end
    end

    assign cycle_num    = cycle_q;
    assign out_valid    = out_valid_q;
    assign matrix_index = matrix_index_q;

    // Read addresses step exactly in the cycles that issue a read: PREFETCH
    // presents the base, each following read presents base+1, base+2, ...
    systolic_addr_gen #(.WIDTH(ADDR_WIDTH)) u_addr_w (
        .clk      (clk),
        .srstn    (srstn),
        .load     (start_acc),
        .load_val (w_base),
        .en       (sram_ren),
        .addr     (sram_raddr_w)
    );

    systolic_addr_gen #(.WIDTH(ADDR_WIDTH)) u_addr_d (
        .clk      (clk),
        .srstn    (srstn),
        .load     (start_acc),
        .load_val (d_base),
        .en       (sram_ren),
        .addr     (sram_raddr_d)
    );

    // Write address advances after each captured result.
    systolic_addr_gen #(.WIDTH(ADDR_WIDTH)) u_addr_o (
        .clk      (clk),
        .srstn    (srstn),
        .load     (start_acc),
        .load_val (o_base),
        .en       (out_valid_q),
        .addr     (out_waddr)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    always_comb begin
        perf_d = perf_q + 32'(alu_start);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Purpose: directed self-checking bench for systolic_ctrl (ARRAY_SIZE=8, ADDR_WIDTH=10).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_systolic_ctrl;

    logic       clk      = 1'b0;
    logic       srstn    = 1'b0;
    logic       start    = 1'b0;
    logic [4:0] tile_num = '0;
    logic [9:0] w_base   = '0;
    logic [9:0] d_base   = '0;
    logic [9:0] o_base   = '0;

    logic       sram_ren;
    logic [9:0] sram_raddr_w;
    logic [9:0] sram_raddr_d;
    logic       feed_zero;
    logic       alu_start;
    logic [8:0] cycle_num;
    logic [5:0] matrix_index;
    logic       out_valid;
    logic [9:0] out_waddr;
    logic       busy;
    logic       done;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Per-job statistics gathered by run_job
    int         alu_cnt;
    int         val_cnt;
    int         done_cnt;
    int         done_at;
    int         max_cyc;
    int         end_at;
    bit         wrap_seen;
    logic [9:0] last_waddr;
    logic [9:0] last_raddr;
    logic [5:0] last_mi;

    systolic_ctrl #(
        .ARRAY_SIZE (8),
        .ADDR_WIDTH (10),
        .TILE_WIDTH (5)
    ) dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .tile_num     (tile_num),
        .w_base       (w_base),
        .d_base       (d_base),
        .o_base       (o_base),
        .sram_ren     (sram_ren),
        .sram_raddr_w (sram_raddr_w),
        .sram_raddr_d (sram_raddr_d),
        .feed_zero    (feed_zero),
        .alu_start    (alu_start),
        .cycle_num    (cycle_num),
        .matrix_index (matrix_index),
        .out_valid    (out_valid),
        .out_waddr    (out_waddr),
        .busy         (busy),
        .done         (done)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one job and follow it cycle by cycle until busy drops. Cycle i=1 is the
    // cycle after the start edge (PREFETCH); n is the effective tile count.
    task automatic run_job(input logic [4:0] tn, input int n, input logic [9:0] wb,
                           input logic [9:0] db, input logic [9:0] ob, input bit poke);
        int         i;
        int         cyc;
        bit         e_pref, e_feed, e_drain, e_done, e_alu, e_ren, e_val;
        logic [9:0] prev_raddr;
        alu_cnt    = 0;
        val_cnt    = 0;
        done_cnt   = 0;
        done_at    = -1;
        max_cyc    = 0;
        wrap_seen  = 1'b0;
        last_waddr = '0;
        last_raddr = '0;
        last_mi    = '0;
        prev_raddr = '0;
        tile_num   = tn;
        w_base     = wb;
        d_base     = db;
        o_base     = ob;
        start      = 1'b1;
        tick();
        start = 1'b0;
        i = 1;
        while ((busy === 1'b1) && (i < 1000)) begin
            e_pref  = (i == 1);
            e_feed  = (i >= 2) && (i <= 1 + 8 * n);
            e_drain = (i >= 2 + 8 * n) && (i <= 17 + 8 * n);
            e_done  = (i == 18 + 8 * n);
            e_alu   = e_feed || e_drain;
            e_ren   = e_pref || (e_feed && (i != 1 + 8 * n));
            cyc     = e_alu ? (i - 2) : (e_done ? (8 * n + 15) : 0);
            e_val   = e_alu && (cyc >= 9);
            check($sformatf("alu_start@%0d", i), 32'(alu_start), 32'(e_alu));
            check($sformatf("sram_ren@%0d", i), 32'(sram_ren), 32'(e_ren));
            check($sformatf("feed_zero@%0d", i), 32'(feed_zero), 32'(e_drain));
            check($sformatf("done@%0d", i), 32'(done), 32'(e_done));
            check($sformatf("cycle_num@%0d", i), 32'(cycle_num), 32'(cyc));
            check($sformatf("out_valid@%0d", i), 32'(out_valid), 32'(e_val));
            check($sformatf("matrix_index@%0d", i), 32'(matrix_index),
                  e_val ? 32'((cyc - 9) % 16) : 32'd0);
            if (e_ren) begin
                check($sformatf("raddr_w@%0d", i), 32'(sram_raddr_w), 32'(10'(32'(wb) + i - 1)));
                check($sformatf("raddr_d@%0d", i), 32'(sram_raddr_d), 32'(10'(32'(db) + i - 1)));
            end
            if (e_val) begin
                check($sformatf("out_waddr@%0d", i), 32'(out_waddr), 32'(10'(32'(ob) + cyc - 9)));
            end
            if (alu_start === 1'b1) alu_cnt++;
            if (out_valid === 1'b1) begin
                val_cnt++;
                last_waddr = out_waddr;
                last_mi    = matrix_index;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (int'(cycle_num) > max_cyc) max_cyc = int'(cycle_num);
            if (sram_ren === 1'b1) begin
                if ((i > 1) && (prev_raddr == 10'h3FF) && (sram_raddr_w == 10'h000)) wrap_seen = 1'b1;
                prev_raddr = sram_raddr_w;
                last_raddr = sram_raddr_w;
            end
            // A second request during FEED, with different parameters, must be ignored.
            if (poke) begin
                start = (i == 5);
                if (i == 5) begin
                    tile_num = 5'd9;
                    w_base   = 10'h2AA;
                    d_base   = 10'h155;
                    o_base   = 10'h0F0;
                end
            end
            tick();
            i++;
        end
        start  = 1'b0;
        end_at = i;
    endtask

    initial begin
        // Reset state
        srstn = 1'b0;
        tick();
        tick();
        check("rst_sram_ren", 32'(sram_ren), 32'd0);
        check("rst_raddr_w", 32'(sram_raddr_w), 32'd0);
        check("rst_raddr_d", 32'(sram_raddr_d), 32'd0);
        check("rst_feed_zero", 32'(feed_zero), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_cycle_num", 32'(cycle_num), 32'd0);
        check("rst_matrix_index", 32'(matrix_index), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_waddr", 32'(out_waddr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("rst_perf", perf_cycles, 32'd0);
`endif
        srstn = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Job 1: single tile
        run_job(5'd1, 1, 10'h010, 10'h020, 10'h100, 1'b0);
        check("j1_alu_cnt", 32'(alu_cnt), 32'd24);
        check("j1_val_cnt", 32'(val_cnt), 32'd15);
        check("j1_last_waddr", 32'(last_waddr), 32'h10E);
        check("j1_last_raddr", 32'(last_raddr), 32'h017);
        check("j1_done_at", 32'(done_at), 32'd26);
        check("j1_done_cnt", 32'(done_cnt), 32'd1);
        check("j1_busy_fall", 32'(end_at), 32'd27);
        check("j1_idle_cycle", 32'(cycle_num), 32'd0);
        check("j1_waddr_post", 32'(out_waddr), 32'h10F);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("j1_perf", perf_cycles, 32'd24);
`endif

        // Job 2: three tiles, matrix_index wraps through 16
        run_job(5'd3, 3, 10'h040, 10'h080, 10'h200, 1'b0);
        check("j2_max_cycle", 32'(max_cyc), 32'd39);
        check("j2_alu_cnt", 32'(alu_cnt), 32'd40);
        check("j2_val_cnt", 32'(val_cnt), 32'd31);
        check("j2_last_mi", 32'(last_mi), 32'd14);
        check("j2_last_waddr", 32'(last_waddr), 32'h21E);
        check("j2_done_at", 32'(done_at), 32'd42);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("j2_perf", perf_cycles, 32'd64);
`endif

        // Job 3: read and write addresses wrap
        run_job(5'd1, 1, 10'h3FC, 10'h3F8, 10'h3FA, 1'b0);
        check("j3_wrap_seen", 32'(wrap_seen), 32'd1);
        check("j3_last_raddr", 32'(last_raddr), 32'h003);
        check("j3_last_waddr", 32'(last_waddr), 32'h008);
        check("j3_done_cnt", 32'(done_cnt), 32'd1);

        // Job 4: extra start during FEED is ignored
        run_job(5'd2, 2, 10'h100, 10'h180, 10'h300, 1'b1);
        check("j4_done_cnt", 32'(done_cnt), 32'd1);
        check("j4_done_at", 32'(done_at), 32'd34);
        check("j4_alu_cnt", 32'(alu_cnt), 32'd32);
        check("j4_busy_fall", 32'(end_at), 32'd35);

        // Job 5: tile_num 0 runs as one tile
        run_job(5'd0, 1, 10'h000, 10'h000, 10'h000, 1'b0);
        check("j5_done_at", 32'(done_at), 32'd26);
        check("j5_alu_cnt", 32'(alu_cnt), 32'd24);

        // Reset in the middle of a job
        tile_num = 5'd1;
        w_base   = 10'h010;
        d_base   = 10'h020;
        o_base   = 10'h100;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; (k < 40) && (cycle_num !== 9'd5); k++) tick();
        check("mid_reach_cyc5", 32'(cycle_num), 32'd5);
        srstn = 1'b0;
        tick();
        check("mid_sram_ren", 32'(sram_ren), 32'd0);
        check("mid_raddr_w", 32'(sram_raddr_w), 32'd0);
        check("mid_raddr_d", 32'(sram_raddr_d), 32'd0);
        check("mid_feed_zero", 32'(feed_zero), 32'd0);
        check("mid_alu_start", 32'(alu_start), 32'd0);
        check("mid_cycle_num", 32'(cycle_num), 32'd0);
        check("mid_matrix_index", 32'(matrix_index), 32'd0);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_waddr", 32'(out_waddr), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        srstn = 1'b1;
        tick();
        check("mid_post_busy", 32'(busy), 32'd0);
        check("mid_post_done", 32'(done), 32'd0);

        // Clean job after the reset
        run_job(5'd1, 1, 10'h050, 10'h060, 10'h070, 1'b0);
        check("j6_done_at", 32'(done_at), 32'd26);
        check("j6_val_cnt", 32'(val_cnt), 32'd15);
        check("j6_last_waddr", 32'(last_waddr), 32'h07E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
